mult8_sequencer: RTL and testbench



---
 rtl/mult8_if.sv | 13 +
 rtl/mult8_sequencer.sv | 105 ++++++++++
 tb/tb_mult8_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mult8_if.sv
// Request/result bus of the 8x8 sequential multiplier.
// The control side is the master and the sequencer is the slave.
interface mult8_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult8_sequencer.sv
// Unsigned 8x8 -> 16 multiply built from four passes through one external 4x4 multiplier.
// Each pass selects a nibble pair, waits MUL_LATENCY cycles, then shift-accumulates mul_p.
module mult8_sequencer #(
  parameter int MUL_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  mult8_if.slave      bus,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  localparam logic [1:0] LAT = 2'(MUL_LATENCY);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  ra, rb;
  logic [15:0] acc;
  logic [15:0] term;
  logic [15:0] acc_sum;
  logic [1:0]  step;
  logic [1:0]  wait_cnt;
  logic        accept;
  logic        step_fire;
  logic        last_step;

  // A new operation is accepted from IDLE and, back-to-back, from DONE.
  assign accept    = (state != STEP) && bus.start;
  assign step_fire = (state == STEP) && (wait_cnt == LAT);
  assign last_step = (step == 2'd3);
  assign acc_sum   = acc + term;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    term = '0;
    case (step)
      2'd0:    term = {8'b0, mul_p};
      2'd1,
      2'd2:    term = {4'b0, mul_p, 4'b0};
      default: term = {mul_p, 8'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = STEP;
      STEP:    if (step_fire && last_step) state_next = DONE;
      DONE:    state_next = bus.start ? STEP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    case (state)
      STEP: begin
        bus.busy = 1'b1;
        mul_a    = step[1] ? ra[7:4] : ra[3:0];
        mul_b    = step[0] ? rb[7:4] : rb[3:0];
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra          <= '0;
      rb          <= '0;
      acc         <= '0;
      step        <= '0;
      wait_cnt    <= '0;
      bus.product <= '0;
    end else if (accept) begin
      ra       <= bus.a;
      rb       <= bus.b;
      acc      <= '0;
      step     <= '0;
      wait_cnt <= '0;
    end else if (state == STEP) begin
      if (step_fire) begin
        acc      <= acc_sum;
        wait_cnt <= '0;
        // The final sum goes straight to product; step stays at 3 until the next accept.
        if (last_step) bus.product <= acc_sum;
        else           step        <= step + 2'd1;
      end else begin
        wait_cnt <= wait_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult8_sequencer.sv
// Directed bench for mult8_sequencer: one instance with a combinational 4x4 multiplier,
// one with MUL_LATENCY=2 fed by a two-stage delayed multiplier model.
module tb_mult8_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mult8_if bus0 ();
  mult8_if bus2 ();

  logic [3:0] mul_a0, mul_b0, mul_a2, mul_b2;
  logic [7:0] mul_p0, mul_p2, p_d1, p_d2;

  assign mul_p0 = {4'b0, mul_a0} * {4'b0, mul_b0};

  always @(posedge clk) begin
    p_d1 <= {4'b0, mul_a2} * {4'b0, mul_b2};
    p_d2 <= p_d1;
  end
  assign mul_p2 = p_d2;

  mult8_sequencer #(.MUL_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0)
  );

  mult8_sequencer #(.MUL_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation on the latency-0 instance: done must show up in the 5th cycle.
  task automatic op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int cycles;
    bus0.start = 1'b1;
    bus0.a     = a;
    bus0.b     = b;
    tick();
    bus0.start = 1'b0;
    cycles = 1;
    while (!bus0.done && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 16'(cycles), 16'd5);
    check({tag, "_product"}, bus0.product, exp);
    tick();
    check({tag, "_done_pulse"}, {15'b0, bus0.done}, 16'd0);
  endtask

  initial begin
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    int         seen;

    rst = 1'b1;
    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    repeat (3) tick();
    check("rst_busy",    {15'b0, bus0.busy}, 16'd0);
    check("rst_done",    {15'b0, bus0.done}, 16'd0);
    check("rst_product", bus0.product,       16'd0);
    check("rst_mul",     {8'b0, mul_a0, mul_b0}, 16'd0);
    rst = 1'b0;
    tick();

    // 0x12 * 0x34: nibble pairs 2/4, 2/3, 1/4, 1/3, one cycle each.
    bus0.start = 1'b1; bus0.a = 8'h12; bus0.b = 8'h34;
    tick();
    bus0.start = 1'b0;
    exp_a = '{4'h2, 4'h2, 4'h1, 4'h1};
    exp_b = '{4'h4, 4'h3, 4'h4, 4'h3};
    for (int s = 0; s < 4; s++) begin
      check($sformatf("seq0_busy_s%0d", s), {15'b0, bus0.busy}, 16'd1);
      check($sformatf("seq0_mul_s%0d", s), {8'b0, mul_a0, mul_b0}, {8'b0, exp_a[s], exp_b[s]});
      tick();
    end
    check("seq0_done",    {15'b0, bus0.done}, 16'd1);
    check("seq0_busy_lo", {15'b0, bus0.busy}, 16'd0);
    check("seq0_product", bus0.product,       16'h03A8);
    tick();
    check("seq0_idle_done", {15'b0, bus0.done}, 16'd0);
    check("seq0_hold",      bus0.product,       16'h03A8);

    op0("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    op0("00_a5", 8'h00, 8'hA5, 16'h0000);

    // start held through busy with changing operands; accepted again in the done cycle.
    bus0.start = 1'b1; bus0.a = 8'h21; bus0.b = 8'h43;
    tick();
    bus0.a = 8'h03; bus0.b = 8'h05;
    repeat (4) tick();
    check("hold_done",    {15'b0, bus0.done}, 16'd1);
    check("hold_product", bus0.product,       16'h08A3);
    tick();
    bus0.start = 1'b0;
    check("b2b_busy",     {15'b0, bus0.busy}, 16'd1);
    check("b2b_mul_s0",   {8'b0, mul_a0, mul_b0}, 16'h0035);
    check("b2b_prev_held", bus0.product,      16'h08A3);
    repeat (4) tick();
    check("b2b_done",    {15'b0, bus0.done}, 16'd1);
    check("b2b_product", bus0.product,       16'h000F);
    tick();

    // Abort at step 2 of 0xFF * 0xFF.
    bus0.start = 1'b1; bus0.a = 8'hFF; bus0.b = 8'hFF;
    tick();
    bus0.start = 1'b0;
    repeat (2) tick();
    check("abort_at_step2", {15'b0, bus0.busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",    {15'b0, bus0.busy}, 16'd0);
    check("abort_done",    {15'b0, bus0.done}, 16'd0);
    check("abort_product", bus0.product,       16'd0);
    check("abort_mul",     {8'b0, mul_a0, mul_b0}, 16'd0);
    seen = 0;
    repeat (8) begin
      if (bus0.done) seen++;
      tick();
    end
    check("abort_no_done", 16'(seen), 16'd0);
    op0("10_10", 8'h10, 8'h10, 16'h0100);

    // MUL_LATENCY=2, 0x9C * 0x47: pairs C/7, C/4, 9/7, 9/4, each held 3 cycles.
    bus2.start = 1'b1; bus2.a = 8'h9C; bus2.b = 8'h47;
    tick();
    bus2.start = 1'b0;
    exp_a = '{4'hC, 4'hC, 4'h9, 4'h9};
    exp_b = '{4'h7, 4'h4, 4'h7, 4'h4};
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("lat2_mul_s%0d_c%0d", s, k), {7'b0, bus2.done, mul_a2, mul_b2},
              {8'b0, exp_a[s], exp_b[s]});
        tick();
      end
    end
    check("lat2_done",    {15'b0, bus2.done}, 16'd1);
    check("lat2_product", bus2.product,       16'h2B44);
    tick();
    check("lat2_done_pulse", {15'b0, bus2.done}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
